multx_rq: RTL

Multiplies a stored sntrup757 polynomial in place by x in Rq = Z_q[x]/(x^P − x − 1): c'[0] = c[P−1], c'[1] = c[0] + c[P−1] mod q, c'[i] = c[i−1] for 2 ≤ i ≤ P−1. It is the up-shift counterpart of the decapsulation lift/down-shift datapath. It drives the same coefficient RAM port style: a read address, a write address and write data. It sits beside the Rq arithmetic units and is launched by the decapsulation controller.

---
 rtl/sntrup_pkg.sv | 22 ++
 rtl/rq_add_freeze.sv | 31 +++
 rtl/multx_rq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sntrup_pkg.sv
// sntrup757 shared constants and coefficient/address types.
// Used by multx_rq and the other Rq arithmetic units.
package sntrup_pkg;

  localparam int P     = 757;
  localparam int Q     = 5167;
  localparam int HALFQ = (Q - 1) / 2;
  localparam int AW    = 11;
  localparam int DW    = 13;

  typedef logic signed [DW-1:0] coef_t;
  typedef logic [AW-1:0]        addr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_TOP,
    SHIFT,
    WR_ONE,
    WR_ZERO
  } state_t;

endpackage

// File: rtl/rq_add_freeze.sv
// Centred modular adder: y = a + b reduced into [-(Q-1)/2, (Q-1)/2].
// Inputs must already be centred, so a single correction suffices.
module rq_add_freeze
  import sntrup_pkg::*;
#(
  parameter int QM = sntrup_pkg::Q
) (
  input  coef_t a,
  input  coef_t b,
  output coef_t y
);

  localparam int HQ = (QM - 1) / 2;
  localparam logic signed [DW:0] HQ_S = (DW+1)'(HQ);
  localparam logic signed [DW:0] Q_S  = (DW+1)'(QM);

  logic signed [DW:0] s;
  logic signed [DW:0] t;

  always_comb begin
    s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    t = s;
    if (s > HQ_S) begin
      t = s - Q_S;
    end else if (s < -HQ_S) begin
      t = s + Q_S;
    end
    y = t[DW-1:0];
  end

endmodule

// File: rtl/multx_rq.sv
// In-place multiply by x in Z_q[x]/(x^P - x - 1) over the coefficient RAM.
// Optional sticky range checker on read words: MULTX_RANGECHK_EN.
module multx_rq
  import sntrup_pkg::*;
#(
  parameter int P  = sntrup_pkg::P,
  parameter int Q  = sntrup_pkg::Q,
  parameter int AW = sntrup_pkg::AW,
  parameter int DW = sntrup_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] mem_output,
  output logic [AW-1:0] mem_address_o,
  output logic [AW-1:0] mem_address_i,
  output logic [DW-1:0] mem_input,
`ifdef MULTX_RANGECHK_EN
  output logic          err,
`endif
  output logic          mem_we
);

  localparam logic [AW-1:0] LAST = AW'(P - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ra_q, ra_d;
  logic          rv_q, rv_d;
  logic          dv_q, dv_d;
  logic [AW-1:0] dk_q, dk_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] top_q, top_d;
  coef_t         sum;

  rq_add_freeze #(.QM(Q)) u_add (
    .a(mem_output),
    .b(top_q),
    .y(sum)
  );

  // rv: address issued this cycle; dv/dk: tag of the word on mem_output
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rv_d    = 1'b0;
    dv_d    = rv_q;
    dk_d    = ra_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    top_d   = top_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_TOP;
          ra_d    = LAST;
          rv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RD_TOP: begin
        state_d = SHIFT;
        ra_d    = ra_q - 1'b1;
        rv_d    = 1'b1;
      end
      SHIFT: begin
        if (rv_q && ra_q != '0) begin
          ra_d = ra_q - 1'b1;
          rv_d = 1'b1;
        end
        if (dv_q) begin
          if (dk_q == LAST) begin
            top_d = mem_output;
          end else if (dk_q != '0) begin
            wa_d = dk_q + 1'b1;
            wd_d = mem_output;
            we_d = 1'b1;
          end else begin
            wa_d    = AW'(1);
            wd_d    = sum;
            we_d    = 1'b1;
            state_d = WR_ONE;
          end
        end
      end
      WR_ONE: begin
        wa_d    = '0;
        wd_d    = top_q;
        we_d    = 1'b1;
        state_d = WR_ZERO;
      end
      WR_ZERO: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rv_q    <= 1'b0;
      dv_q    <= 1'b0;
      dk_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rv_q    <= rv_d;
      dv_q    <= dv_d;
      dk_q    <= dk_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      top_q   <= top_d;
    end
  end

`ifdef MULTX_RANGECHK_EN
  localparam logic signed [DW-1:0] HQ_S = DW'((Q - 1) / 2);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) begin
      err_d = 1'b0;
    end
    if (dv_q && ($signed(mem_output) > HQ_S ||
                 $signed(mem_output) < -HQ_S)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_address_o = ra_q;
  assign mem_address_i = wa_q;
  assign mem_input     = wd_q;
  assign mem_we        = we_q;

endmodule
